// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte FIFO between the UART byte analyser (writer) and the host
// (reader). Circular buffer of 2^DEPTH_LOG2 bytes with a registered read port,
// occupancy count, status flags derived from the count, and sticky
// overflow/underflow indicators.
//
// Ports
//   clk           in   system clock, rising edge active
//   rst           in   asynchronous active-low reset (release sync to clk)
//   n_we_i        in   active-low write strobe, one byte per low cycle
//   data_i        in   byte to store on an accepted write
//   p_full_o      out  count == 2^DEPTH_LOG2
//   n_re_i        in   active-low read strobe
//   data_o        out  registered read data, valid the cycle after the strobe
//   p_empty_o     out  count == 0
//   p_afull_o     out  count >= AFULL_LEVEL
//   count_o       out  number of stored bytes (DEPTH_LOG2+1 bits)
//   p_overflow_o  out  sticky: write attempted while full
//   p_underflow_o out  sticky: read attempted while empty
//   p_clear_i     in   synchronous flush of contents, data_o and sticky flags
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  n_we_i,
    input  logic [7:0]            data_i,
    output logic                  p_full_o,
    input  logic                  n_re_i,
    output logic [7:0]            data_o,
    output logic                  p_empty_o,
    output logic                  p_afull_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  p_overflow_o,
    output logic                  p_underflow_o,
    input  logic                  p_clear_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0]         FULL_COUNT  = CW'(DEPTH);
    localparam logic [CW-1:0]         AFULL_COUNT = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0]         COUNT_ONE   = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);

    // Storage and state
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [7:0]            data_r;
    logic                  overflow_r;
    logic                  underflow_r;

    // Next-state values
    logic [DEPTH_LOG2-1:0] wr_ptr_next_s;
    logic [DEPTH_LOG2-1:0] rd_ptr_next_s;
    logic [CW-1:0]         count_next_s;
    logic [7:0]            data_next_s;
    logic                  overflow_next_s;
    logic                  underflow_next_s;

    // Strobe decode and acceptance
    logic wr_req_s;
    logic rd_req_s;
    logic full_s;
    logic empty_s;
    logic wr_acc_s;
    logic rd_acc_s;

    // Status flags come straight from the count register so they reflect the
    // pre-edge occupancy used for accept/reject decisions.
    assign full_s   = (count_r == FULL_COUNT);
    assign empty_s  = (count_r == {CW{1'b0}});
    assign wr_req_s = ~n_we_i;
    assign rd_req_s = ~n_re_i;

    // A write into a full FIFO is refused even if a read frees a slot on the
    // same edge; likewise a read from an empty FIFO ignores a same-edge write.
    assign wr_acc_s = wr_req_s & ~full_s;
    assign rd_acc_s = rd_req_s & ~empty_s;

    // Next-state computation for pointers, count, read data and sticky flags
    always_comb begin
        wr_ptr_next_s    = wr_ptr_r;
        rd_ptr_next_s    = rd_ptr_r;
        count_next_s     = count_r;
        data_next_s      = data_r;
        overflow_next_s  = overflow_r;
        underflow_next_s = underflow_r;

        if (p_clear_i) begin
            // Flush wins over any strobe on the same edge.
            wr_ptr_next_s    = {DEPTH_LOG2{1'b0}};
            rd_ptr_next_s    = {DEPTH_LOG2{1'b0}};
            count_next_s     = {CW{1'b0}};
            data_next_s      = 8'h00;
            overflow_next_s  = 1'b0;
            underflow_next_s = 1'b0;
        end else begin
            case ({wr_acc_s, rd_acc_s})
                2'b10: begin
                    wr_ptr_next_s = wr_ptr_r + PTR_ONE;
                    count_next_s  = count_r + COUNT_ONE;
                end
                2'b01: begin
                    rd_ptr_next_s = rd_ptr_r + PTR_ONE;
                    count_next_s  = count_r - COUNT_ONE;
                    data_next_s   = mem_r[rd_ptr_r];
                end
                2'b11: begin
                    wr_ptr_next_s = wr_ptr_r + PTR_ONE;
                    rd_ptr_next_s = rd_ptr_r + PTR_ONE;
                    data_next_s   = mem_r[rd_ptr_r];
                end
                default: begin
                    wr_ptr_next_s = wr_ptr_r;
                    rd_ptr_next_s = rd_ptr_r;
                end
            endcase

            overflow_next_s  = overflow_r  | (wr_req_s & full_s);
            underflow_next_s = underflow_r | (rd_req_s & empty_s);
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
            count_r     <= {CW{1'b0}};
            data_r      <= 8'h00;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            data_r      <= data_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

    // Buffer RAM write port; contents are not reset, stale bytes are
    // unreachable once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !p_clear_i) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    assign p_full_o      = full_s;
    assign p_empty_o     = empty_s;
    assign p_afull_o     = (count_r >= AFULL_COUNT);
    assign count_o       = count_r;
    assign data_o        = data_r;
    assign p_overflow_o  = overflow_r;
    assign p_underflow_o = underflow_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       n_we_i;
    logic [7:0] data_i;
    logic       p_full_o;
    logic       n_re_i;
    logic [7:0] data_o;
    logic       p_empty_o;
    logic       p_afull_o;
    logic [4:0] count_o;
    logic       p_overflow_o;
    logic       p_underflow_o;
    logic       p_clear_i;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_data;
    bit         m_ovf;
    bit         m_unf;

    uart_rx_fifo #(.DEPTH_LOG2(4), .AFULL_LEVEL(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .n_we_i        (n_we_i),
        .data_i        (data_i),
        .p_full_o      (p_full_o),
        .n_re_i        (n_re_i),
        .data_o        (data_o),
        .p_empty_o     (p_empty_o),
        .p_afull_o     (p_afull_o),
        .count_o       (count_o),
        .p_overflow_o  (p_overflow_o),
        .p_underflow_o (p_underflow_o),
        .p_clear_i     (p_clear_i)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = mq.size();
        check_eq({tag, ".count"},     32'(count_o),       32'(n));
        check_eq({tag, ".empty"},     32'(p_empty_o),     32'(n == 0));
        check_eq({tag, ".full"},      32'(p_full_o),      32'(n == 16));
        check_eq({tag, ".afull"},     32'(p_afull_o),     32'(n >= 12));
        check_eq({tag, ".data"},      32'(data_o),        32'(m_data));
        check_eq({tag, ".overflow"},  32'(p_overflow_o),  32'(m_ovf));
        check_eq({tag, ".underflow"}, 32'(p_underflow_o), 32'(m_unf));
    endtask

    // One clock cycle of stimulus; the model applies the same strobes using
    // the occupancy seen before the edge.
    task automatic cycle(input bit we, input bit re, input bit clr,
                         input logic [7:0] d, input string tag);
        bit was_full;
        bit was_empty;
        n_we_i    = ~we;
        n_re_i    = ~re;
        p_clear_i = clr;
        data_i    = d;
        @(posedge clk);
        #1;
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (clr) begin
            model_reset();
        end else begin
            if (re && !was_empty) m_data = mq.pop_front();
            if (we && !was_full)  mq.push_back(d);
            if (we && was_full)   m_ovf = 1'b1;
            if (re && was_empty)  m_unf = 1'b1;
        end
        n_we_i    = 1'b1;
        n_re_i    = 1'b1;
        p_clear_i = 1'b0;
        compare_all(tag);
    endtask

    initial begin
        rst       = 1'b0;
        n_we_i    = 1'b1;
        n_re_i    = 1'b1;
        p_clear_i = 1'b0;
        data_i    = 8'h00;
        model_reset();

        // Reset state
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Two bytes in, two bytes out
        cycle(1, 0, 0, 8'hA5, "wr_a5");
        cycle(1, 0, 0, 8'h3C, "wr_3c");
        cycle(0, 1, 0, 8'h00, "rd_a5");
        check_eq("rd_a5_value", 32'(data_o), 32'h0000_00A5);
        cycle(0, 1, 0, 8'h00, "rd_3c");
        check_eq("rd_3c_value", 32'(data_o), 32'h0000_003C);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 0, 8'(i), "fill");
            if (i == 11) check_eq("afull_at_12", 32'(p_afull_o), 32'd1);
        end
        check_eq("full_at_16", 32'(p_full_o), 32'd1);
        cycle(1, 0, 0, 8'hFF, "wr17");
        check_eq("ovf_wr17", 32'(p_overflow_o), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, 8'h00, "drain");
            check_eq("drain_order", 32'(data_o), 32'(i));
        end

        // Simultaneous strobes at full and at empty
        cycle(0, 0, 1, 8'h00, "clr0");
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'($urandom), "fill2");
        cycle(1, 1, 0, 8'h77, "both_full");
        check_eq("both_full_cnt", 32'(count_o), 32'd15);
        for (int i = 0; i < 15; i++) cycle(0, 1, 0, 8'h00, "drain2");
        cycle(1, 1, 0, 8'h5A, "both_empty");
        check_eq("both_empty_cnt", 32'(count_o), 32'd1);
        check_eq("both_empty_unf", 32'(p_underflow_o), 32'd1);

        // Steady streaming at count 5 across pointer wrap
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'($urandom), "to5");
        for (int i = 0; i < 40; i++) cycle(1, 1, 0, 8'($urandom), "stream");
        check_eq("stream_cnt", 32'(count_o), 32'd5);

        // Clear at count 7 with overflow set and a write pending
        for (int i = 0; i < 11; i++) cycle(1, 0, 0, 8'($urandom), "to16");
        cycle(1, 0, 0, 8'hEE, "ovf_again");
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 8'h00, "to7");
        check_eq("pre_clr_cnt", 32'(count_o), 32'd7);
        cycle(1, 0, 1, 8'h99, "clear");

        // Asynchronous reset between edges at count 9
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, 8'($urandom), "to9");
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 1, 0, 8'h00, "first_rd");

        // Random traffic in phases of varying write/read bias
        for (int ph = 0; ph < 24; ph++) begin
            int wp;
            int rp;
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 100; i++) begin
                cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                      $urandom_range(0, 199) == 0, 8'($urandom), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
